// File: rtl/shift_add_mult_engine.sv
// Iterative shift-add unsigned multiplier; one partial product per clock, done WIDTH edges after start.
// No backpressure: start is sampled only in IDLE; a start while busy is dropped, not queued.
module shift_add_mult_engine #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   result
);

    localparam logic [1:0]       S_IDLE   = 2'd0;
    localparam logic [1:0]       S_RUN    = 2'd1;
    localparam logic [1:0]       S_DONE   = 2'd2;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    logic [1:0]         state_q,  state_d;
    logic [2*WIDTH-1:0] ma_q,     ma_d;
    logic [WIDTH-1:0]   mb_q,     mb_d;
    logic [2*WIDTH-1:0] acc_q,    acc_d;
    logic [CNT_W-1:0]   cnt_q,    cnt_d;
    logic [2*WIDTH-1:0] result_q, result_d;
    logic [2*WIDTH-1:0] acc_sum;

    // The final iteration's add must land in result on the same edge, so use the summed value.
    assign acc_sum = mb_q[0] ? (acc_q + ma_q) : acc_q;

    always_comb begin
        state_d  = state_q;
        ma_d     = ma_q;
        mb_d     = mb_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    ma_d    = {{WIDTH{1'b0}}, a};
                    mb_d    = b;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                acc_d = acc_sum;
                ma_d  = ma_q << 1;
                mb_d  = mb_q >> 1;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_CNT) begin
                    result_d = acc_sum;
                    state_d  = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            ma_q     <= '0;
            mb_q     <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            ma_q     <= ma_d;
            mb_q     <= mb_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
        end
    end

    assign busy   = (state_q == S_RUN) || (state_q == S_DONE);
    assign done   = (state_q == S_DONE);
    assign result = result_q;

endmodule

// File: tb/tb_shift_add_mult_engine.sv
// Bench for shift_add_mult_engine: scenario tasks compare against a plain a*b and edge-count model.
module tb_shift_add_mult_engine;

    localparam int WIDTH = 8;
    localparam int CNT_W = 4;

    logic                 clk = 1'b0;
    logic                 rst = 1'b0;
    logic                 start = 1'b0;
    logic [WIDTH-1:0]     a = '0;
    logic [WIDTH-1:0]     b = '0;
    logic                 busy;
    logic                 done;
    logic [2*WIDTH-1:0]   result;

    int checks   = 0;
    int failures = 0;

    shift_add_mult_engine #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    always #5 clk = ~clk;

    // Pulses start for one edge (edge 0), then watches edges 1..WIDTH+1, sampling 1ns after each.
    task automatic do_op(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                         output int done_cnt, output int done_edge,
                         output logic busy0, output logic busy_end,
                         output logic [2*WIDTH-1:0] res);
        a = av;
        b = bv;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        busy0 = busy;
        done_cnt = 0;
        done_edge = -1;
        res = '0;
        for (int e = 1; e <= WIDTH + 1; e++) begin
            @(posedge clk); #1;
            if (done) begin
                done_cnt++;
                if (done_edge < 0) begin
                    done_edge = e;
                    res = result;
                end
            end
        end
        busy_end = busy;
    endtask

    task automatic test_reset();
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0b exp=0", busy); end
        checks++;
        if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%0b exp=0", done); end
        checks++;
        if (result !== '0) begin failures++; $display("FAIL reset_result got=%0d exp=0", result); end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv, input string tag);
        int dc, de;
        logic b0, be;
        logic [2*WIDTH-1:0] res, exp_res;
        exp_res = (2*WIDTH)'(av) * (2*WIDTH)'(bv);
        do_op(av, bv, dc, de, b0, be, res);
        checks++;
        if (b0 !== 1'b1) begin failures++; $display("FAIL %s_busy_edge0 got=%0b exp=1", tag, b0); end
        checks++;
        if (dc != 1) begin failures++; $display("FAIL %s_done_count got=%0d exp=1", tag, dc); end
        checks++;
        if (de != WIDTH) begin failures++; $display("FAIL %s_latency got=%0d exp=%0d", tag, de, WIDTH); end
        checks++;
        if (res !== exp_res) begin failures++; $display("FAIL %s_result got=%0d exp=%0d", tag, res, exp_res); end
        checks++;
        if (be !== 1'b0) begin failures++; $display("FAIL %s_busy_end got=%0b exp=0", tag, be); end
    endtask

    task automatic test_random();
        int dc, de, bad;
        logic b0, be;
        logic [WIDTH-1:0] av, bv;
        logic [2*WIDTH-1:0] res, exp_res;
        bad = 0;
        for (int i = 0; i < 30; i++) begin
            av = WIDTH'($urandom_range(0, (1 << WIDTH) - 1));
            bv = WIDTH'($urandom_range(0, (1 << WIDTH) - 1));
            exp_res = (2*WIDTH)'(av) * (2*WIDTH)'(bv);
            do_op(av, bv, dc, de, b0, be, res);
            checks++;
            if (res !== exp_res || dc != 1 || de != WIDTH) begin
                failures++;
                $display("FAIL random_%0d a=%0d b=%0d got=%0d exp=%0d done_cnt=%0d latency=%0d",
                         i, av, bv, res, exp_res, dc, de);
            end
        end
    endtask

    task automatic test_change_operands();
        int dc;
        logic [2*WIDTH-1:0] res;
        a = 8'd7;
        b = 8'd9;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        dc = 0;
        res = '0;
        for (int e = 1; e <= WIDTH + 1; e++) begin
            @(posedge clk); #1;
            if (e == 2) begin a = 8'd1; b = 8'd1; end
            if (e == 4) start = 1'b1;
            if (e == 5) start = 1'b0;
            if (done) begin dc++; res = result; end
        end
        checks++;
        if (res !== 16'd63) begin failures++; $display("FAIL chg_result got=%0d exp=63", res); end
        checks++;
        if (dc != 1) begin failures++; $display("FAIL chg_done_count got=%0d exp=1", dc); end
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL chg_idle busy=%0b exp=0", busy); end
    endtask

    task automatic test_back_to_back();
        int d_edges[$];
        int hold_err;
        logic [2*WIDTH-1:0] r_first;
        hold_err = 0;
        r_first = '0;
        a = 8'd3;
        b = 8'd5;
        start = 1'b1;
        @(posedge clk); #1;
        a = 8'd6;
        b = 8'd7;
        for (int e = 1; e <= 2*WIDTH + 4; e++) begin
            @(posedge clk); #1;
            if (done) d_edges.push_back(e);
            if (e == WIDTH) r_first = result;
            if (e > WIDTH && e < 2*WIDTH + 2 && result !== 16'd15) hold_err++;
            if (e == WIDTH + 2) start = 1'b0;
        end
        checks++;
        if (d_edges.size() != 2) begin
            failures++; $display("FAIL b2b_done_count got=%0d exp=2", d_edges.size());
        end else begin
            checks++;
            if (d_edges[1] - d_edges[0] != WIDTH + 2) begin
                failures++; $display("FAIL b2b_spacing got=%0d exp=%0d", d_edges[1] - d_edges[0], WIDTH + 2);
            end
        end
        checks++;
        if (r_first !== 16'd15) begin failures++; $display("FAIL b2b_first got=%0d exp=15", r_first); end
        checks++;
        if (hold_err != 0) begin failures++; $display("FAIL b2b_hold bad_cycles=%0d exp=0", hold_err); end
        checks++;
        if (result !== 16'd42) begin failures++; $display("FAIL b2b_second got=%0d exp=42", result); end
    endtask

    task automatic test_reset_mid();
        a = 8'd100;
        b = 8'd100;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #2 rst = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL rstmid_busy got=%0b exp=0", busy); end
        checks++;
        if (done !== 1'b0) begin failures++; $display("FAIL rstmid_done got=%0b exp=0", done); end
        checks++;
        if (result !== '0) begin failures++; $display("FAIL rstmid_result got=%0d exp=0", result); end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        test_basic(8'd12, 8'd12, "after_rst");
    endtask

    initial begin
        #2;
        test_reset();
        test_basic(8'd13, 8'd11, "basic");
        test_basic(8'd255, 8'd255, "max");
        test_basic(8'd0, 8'd200, "zero_a");
        test_basic(8'd200, 8'd0, "zero_b");
        test_random();
        test_change_operands();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
